// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus master: register map, CON bit layout,
// controller states and the bus request payload.
package uart_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CON_W  = 5;

  localparam logic [ADDR_W-1:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [ADDR_W-1:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [ADDR_W-1:0] UART_CON_ADDR = 32'h4000_0020;

  // CON register bit indices
  localparam int unsigned TXIE   = 0;
  localparam int unsigned RXIE   = 1;
  localparam int unsigned TXF    = 2;
  localparam int unsigned RXF    = 3;
  localparam int unsigned TXBUSY = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_POLL,
    S_RX,
    S_TX,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Read strobe to a register; write data held at zero.
  function automatic bus_req_t bus_read(input logic [ADDR_W-1:0] a);
    bus_req_t r;
    r       = '0;
    r.rd    = 1'b1;
    r.addr  = a;
    return r;
  endfunction

  // Write strobe with data to a register.
  function automatic bus_req_t bus_write(input logic [ADDR_W-1:0] a,
                                         input logic [DATA_W-1:0] d);
    bus_req_t r;
    r       = '0;
    r.wr    = 1'b1;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Bus-side register port plus client byte streams of the UART bus master.
interface uart_bus_master_if;
  import uart_pkg::*;

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rd, wr, addr, wdata, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  rd, wr, addr, wdata, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO with registered head, full and empty flags.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0] count, count_d;
  logic             do_push, do_pop;
  logic [7:0]       head_d;

  // Accept/pop qualification, occupancy and next head value.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    rd_ptr_nx = rd_ptr + PTR_W'(1);
    count_d   = count;
    head_d    = head;
    if (do_push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count - CNT_W'(1);
    end
    if (do_pop) begin
      head_d = (do_push && (rd_ptr_nx == wr_ptr)) ? push_data : mem[rd_ptr_nx];
    end else if (empty && do_push) begin
      head_d = push_data;
    end
  end

  // Storage array; contents need no reset since the flags gate its use.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and registered status/head.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
      head  <= head_d;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Hardware bus initiator for the UART register block: configures CON once,
// then polls it, drains RX bytes into a FIFO and writes client TX bytes.
module uart_bus_master
  import uart_pkg::*;
#(
  parameter logic [CON_W-1:0] CON_INIT = 5'b00011,
  parameter int unsigned      SETTLE   = 3,
  parameter int unsigned      RX_DEPTH = 4
) (
  input logic               CLK,
  input logic               reset,
  uart_bus_master_if.master bus
);

  localparam int unsigned SETTLE_W = 4;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  bus_req_t            bus_q, bus_d;
  logic                tx_ready_q, tx_ready_d;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [BYTE_W-1:0]   fifo_head;
  logic                unused_rdata;

  assign fifo_push    = (state_q == S_RX);
  assign fifo_pop     = bus.rx_ready && !fifo_empty;
  assign unused_rdata = ^bus.rdata[DATA_W-1:BYTE_W];

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.rdata[BYTE_W-1:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Next state, settle count and the bus request presented next cycle.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    bus_d      = '0;
    tx_ready_d = 1'b0;
    unique case (state_q)
      // Hold until the CON write has actually been driven; the cycle right
      // after reset presents an idle bus.
      S_INIT: if (bus_q.wr) state_d = S_POLL;
      S_POLL: begin
        if (bus.rdata[RXF] && !fifo_full) begin
          state_d = S_RX;
        end else if (bus.tx_valid && !bus.rdata[TXBUSY]) begin
          state_d = S_TX;
        end
      end
      S_RX, S_TX: begin
        state_d  = S_HOLD;
        settle_d = '0;
      end
      S_HOLD: begin
        if (settle_q == SETTLE_W'(SETTLE - 1)) begin
          state_d  = S_POLL;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
    unique case (state_d)
      S_INIT: bus_d = bus_write(UART_CON_ADDR, DATA_W'(CON_INIT));
      S_POLL: bus_d = bus_read(UART_CON_ADDR);
      S_RX:   bus_d = bus_read(UART_RXD_ADDR);
      S_TX: begin
        bus_d      = bus_write(UART_TXD_ADDR, DATA_W'(bus.tx_data));
        tx_ready_d = 1'b1;
      end
      default: bus_d = '0;
    endcase
  end

  // State, settle counter and registered bus/handshake outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_INIT;
      settle_q   <= '0;
      bus_q      <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      bus_q      <= bus_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign bus.rd       = bus_q.rd;
  assign bus.wr       = bus_q.wr;
  assign bus.addr     = bus_q.addr;
  assign bus.wdata    = bus_q.wdata;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = !fifo_empty;
  assign bus.rx_data  = fifo_head;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: models the UART register block and checks the
// bus sequence and byte streams against queued expectations.
module tb_uart_bus_master;
  import uart_pkg::*;

  logic CLK;
  logic reset;

  uart_bus_master_if ifc ();

  uart_bus_master #(
    .CON_INIT (5'b00011),
    .SETTLE   (3),
    .RX_DEPTH (4)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (ifc)
  );

  int         vectors;
  int         miscompares;
  logic [7:0] line_q[$];
  logic [7:0] exp_q[$];
  logic       line_rxf;
  logic [7:0] line_head;
  logic       tx_busy;

  // Peripheral read mux: CON = {busy, rx flag, 0,0,0}, RXD = oldest line byte.
  assign ifc.rdata = !ifc.rd ? 32'h0 :
                     (ifc.addr == UART_CON_ADDR) ? {27'h0, tx_busy, line_rxf, 3'b000} :
                     (ifc.addr == UART_RXD_ADDR) ? {24'h0, line_head} : 32'h0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic sync_line();
    line_rxf  = (line_q.size() != 0);
    line_head = (line_q.size() != 0) ? line_q[0] : 8'h00;
  endtask

  // One clock; an RXD read seen before the edge consumes the peripheral byte.
  task automatic tick();
    logic rxd_read;
    rxd_read = ifc.rd && (ifc.addr == UART_RXD_ADDR);
    @(posedge CLK);
    if (rxd_read && line_q.size() != 0) void'(line_q.pop_front());
    #1;
    sync_line();
  endtask

  task automatic test_reset();
    int writes;
    reset = 1'b1; tx_valid_set(1'b0, 8'h00); ifc.rx_ready = 1'b0; tx_busy = 1'b0;
    sync_line();
    repeat (3) tick();
    vectors++;
    if (ifc.rd !== 1'b0 || ifc.wr !== 1'b0 || ifc.addr !== 32'h0 || ifc.wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: rd=%b wr=%b addr=%h wdata=%h, want all zero", ifc.rd, ifc.wr, ifc.addr, ifc.wdata);
    end
    vectors++;
    if (ifc.rx_valid !== 1'b0 || ifc.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: rx_valid=%b tx_ready=%b, want 0 0", ifc.rx_valid, ifc.tx_ready);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (ifc.wr !== 1'b1 || ifc.rd !== 1'b0 || ifc.addr !== UART_CON_ADDR || ifc.wdata !== 32'h3) begin
      miscompares++;
      $display("FAIL init_write: rd=%b wr=%b addr=%h wdata=%h, want 0 1 40000020 00000003", ifc.rd, ifc.wr, ifc.addr, ifc.wdata);
    end
    tick();
    vectors++;
    if (ifc.rd !== 1'b1 || ifc.wr !== 1'b0 || ifc.addr !== UART_CON_ADDR) begin
      miscompares++;
      $display("FAIL first_poll: rd=%b wr=%b addr=%h, want 1 0 40000020", ifc.rd, ifc.wr, ifc.addr);
    end
    writes = 0;
    repeat (6) begin
      tick();
      if (ifc.wr === 1'b1 || ifc.rd !== 1'b1) writes++;
    end
    vectors++;
    if (writes != 0) begin
      miscompares++;
      $display("FAIL idle_polling: %0d non-poll cycles, want 0", writes);
    end
  endtask

  task automatic tx_valid_set(input logic v, input logic [7:0] d);
    ifc.tx_valid = v;
    ifc.tx_data  = d;
  endtask

  task automatic test_tx();
    logic [7:0] e;
    int idle;
    exp_q.push_back(8'hA5);
    tx_valid_set(1'b1, 8'hA5);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (ifc.wr !== 1'b1 || ifc.rd !== 1'b0 || ifc.addr !== UART_TXD_ADDR ||
        ifc.wdata !== {24'h0, e} || ifc.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_write: wr=%b addr=%h wdata=%h tx_ready=%b, want 1 40000018 %h 1", ifc.wr, ifc.addr, ifc.wdata, ifc.tx_ready, {24'h0, e});
    end
    tx_valid_set(1'b0, 8'h00);
    idle = 0;
    repeat (3) begin
      tick();
      if (!ifc.rd && !ifc.wr && !ifc.tx_ready) idle++;
    end
    vectors++;
    if (idle != 3) begin
      miscompares++;
      $display("FAIL tx_settle: %0d idle cycles, want 3", idle);
    end
    tick();
    vectors++;
    if (ifc.rd !== 1'b1 || ifc.addr !== UART_CON_ADDR) begin
      miscompares++;
      $display("FAIL tx_repoll: rd=%b addr=%h, want 1 40000020", ifc.rd, ifc.addr);
    end
  endtask

  task automatic test_tx_busy();
    int early;
    tx_busy = 1'b1;
    tx_valid_set(1'b1, 8'h3E);
    exp_q.push_back(8'h3E);
    early = 0;
    repeat (8) begin
      tick();
      if (ifc.tx_ready === 1'b1 || ifc.wr === 1'b1) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL tx_busy_block: %0d writes while busy, want 0", early);
    end
    tx_busy = 1'b0;
    tick();
    vectors++;
    if (ifc.tx_ready !== 1'b1 || ifc.wdata !== {24'h0, exp_q.pop_front()}) begin
      miscompares++;
      $display("FAIL tx_after_busy: tx_ready=%b wdata=%h, want 1 0000003e", ifc.tx_ready, ifc.wdata);
    end
    tx_valid_set(1'b0, 8'h00);
    repeat (4) tick();
  endtask

  task automatic test_rx();
    logic [7:0] e;
    int idle;
    ifc.rx_ready = 1'b0;
    line_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    sync_line();
    tick();
    vectors++;
    if (ifc.rd !== 1'b1 || ifc.wr !== 1'b0 || ifc.addr !== UART_RXD_ADDR) begin
      miscompares++;
      $display("FAIL rx_read: rd=%b wr=%b addr=%h, want 1 0 4000001c", ifc.rd, ifc.wr, ifc.addr);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== e) begin
      miscompares++;
      $display("FAIL rx_data: rx_valid=%b rx_data=%h, want 1 %h", ifc.rx_valid, ifc.rx_data, e);
    end
    idle = (!ifc.rd && !ifc.wr) ? 1 : 0;
    repeat (2) begin
      tick();
      if (!ifc.rd && !ifc.wr) idle++;
    end
    tick();
    vectors++;
    if (idle != 3 || ifc.rd !== 1'b1 || ifc.addr !== UART_CON_ADDR) begin
      miscompares++;
      $display("FAIL rx_settle: idle=%0d rd=%b addr=%h, want 3 1 40000020", idle, ifc.rd, ifc.addr);
    end
    ifc.rx_ready = 1'b1;
    tick();
    ifc.rx_ready = 1'b0;
    vectors++;
    if (ifc.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_pop: rx_valid=%b, want 0", ifc.rx_valid);
    end
  endtask

  task automatic test_priority();
    logic [7:0] e;
    int lat;
    line_q.push_back(8'h77);
    exp_q.push_back(8'h77);
    sync_line();
    tx_valid_set(1'b1, 8'h55);
    tick();
    vectors++;
    if (ifc.rd !== 1'b1 || ifc.addr !== UART_RXD_ADDR || ifc.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_rx_first: rd=%b addr=%h tx_ready=%b, want 1 4000001c 0", ifc.rd, ifc.addr, ifc.tx_ready);
    end
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifc.tx_ready === 1'b1) begin
        lat = i + 1;
        break;
      end
    end
    vectors++;
    if (lat != 5 || ifc.addr !== UART_TXD_ADDR || ifc.wdata !== 32'h55) begin
      miscompares++;
      $display("FAIL prio_tx_later: latency=%0d addr=%h wdata=%h, want 5 40000018 00000055", lat, ifc.addr, ifc.wdata);
    end
    tx_valid_set(1'b0, 8'h00);
    e = exp_q.pop_front();
    vectors++;
    if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== e) begin
      miscompares++;
      $display("FAIL prio_rx_byte: rx_valid=%b rx_data=%h, want 1 %h", ifc.rx_valid, ifc.rx_data, e);
    end
    ifc.rx_ready = 1'b1;
    tick();
    ifc.rx_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] e;
    int reads;
    int seen;
    ifc.rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      line_q.push_back(8'(b));
      exp_q.push_back(8'(b));
    end
    sync_line();
    reads = 0;
    repeat (40) begin
      if (ifc.rd === 1'b1 && ifc.addr === UART_RXD_ADDR) reads++;
      tick();
    end
    vectors++;
    if (reads != 4 || line_q.size() != 1) begin
      miscompares++;
      $display("FAIL full_stall: rxd reads=%0d left in uart=%0d, want 4 1", reads, line_q.size());
    end
    e = exp_q.pop_front();
    vectors++;
    if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== e) begin
      miscompares++;
      $display("FAIL full_head: rx_valid=%b rx_data=%h, want 1 %h", ifc.rx_valid, ifc.rx_data, e);
    end
    ifc.rx_ready = 1'b1;
    tick();
    ifc.rx_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.rd === 1'b1 && ifc.addr === UART_RXD_ADDR) begin
        seen = 1;
        break;
      end
      tick();
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL full_resume: rxd read seen=%0d, want 1", seen);
    end
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 20 && ifc.rx_valid !== 1'b1; t++) tick();
      e = exp_q.pop_front();
      vectors++;
      if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== e) begin
        miscompares++;
        $display("FAIL full_order: rx_valid=%b rx_data=%h, want 1 %h", ifc.rx_valid, ifc.rx_data, e);
      end
      ifc.rx_ready = 1'b1;
      tick();
      ifc.rx_ready = 1'b0;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int found;
    ifc.rx_ready = 1'b0;
    line_q.push_back(8'hAA);
    line_q.push_back(8'hBB);
    sync_line();
    for (int t = 0; t < 40 && line_q.size() != 0; t++) tick();
    vectors++;
    if (ifc.rx_valid !== 1'b1 || ifc.rx_data !== 8'hAA) begin
      miscompares++;
      $display("FAIL mid_fill: rx_valid=%b rx_data=%h, want 1 aa", ifc.rx_valid, ifc.rx_data);
    end
    tx_valid_set(1'b1, 8'h99);
    found = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (ifc.tx_ready === 1'b1) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (found != 1 || ifc.wdata !== 32'h99) begin
      miscompares++;
      $display("FAIL mid_tx: accepted=%0d wdata=%h, want 1 00000099", found, ifc.wdata);
    end
    tx_valid_set(1'b0, 8'h00);
    tick();
    reset = 1'b1;
    tx_valid_set(1'b1, 8'h42);
    tick();
    vectors++;
    if (ifc.rx_valid !== 1'b0 || ifc.rd !== 1'b0 || ifc.wr !== 1'b0 || ifc.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: rx_valid=%b rd=%b wr=%b tx_ready=%b, want 0 0 0 0", ifc.rx_valid, ifc.rd, ifc.wr, ifc.tx_ready);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (ifc.wr !== 1'b1 || ifc.addr !== UART_CON_ADDR || ifc.wdata !== 32'h3 || ifc.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reinit: wr=%b addr=%h wdata=%h tx_ready=%b, want 1 40000020 00000003 0", ifc.wr, ifc.addr, ifc.wdata, ifc.tx_ready);
    end
    tick();
    vectors++;
    if (ifc.rd !== 1'b1 || ifc.addr !== UART_CON_ADDR || ifc.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_repoll: rd=%b addr=%h tx_ready=%b, want 1 40000020 0", ifc.rd, ifc.addr, ifc.tx_ready);
    end
    tick();
    vectors++;
    if (ifc.tx_ready !== 1'b1 || ifc.wdata !== 32'h42) begin
      miscompares++;
      $display("FAIL mid_new_tx: tx_ready=%b wdata=%h, want 1 00000042", ifc.tx_ready, ifc.wdata);
    end
    tx_valid_set(1'b0, 8'h00);
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    tx_busy     = 1'b0;
    ifc.rx_ready = 1'b0;
    tx_valid_set(1'b0, 8'h00);
    sync_line();
    test_reset();
    test_tx();
    test_tx_busy();
    test_rx();
    test_priority();
    test_fifo_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus initiator that drives the memory-mapped UART peripheral's rd/wr/addr/wdata/rdata port on behalf of a hardware client, without the CPU.
- Polls the UART control register and writes queued TX bytes to the TX data register.
- Drains received bytes from the RX data register into a small FIFO.
- Sits between a byte-stream client (valid/ready) and the UART register map at 0x40000018/1C/20.

Parameters:
- CON_INIT, 5'b00011, value written to the control register after reset (bit0 TX-flag enable, bit1 RX-flag enable).
- SETTLE, 3, idle cycles after any RXD read or TXD write before the next poll (covers peripheral flag/busy latency); legal 1..15.
- RX_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd  out  1  bus read strobe
- wr  out  1  bus write strobe
- addr  out  32  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data; valid combinationally in the same cycle as rd
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid; must be held, with tx_data stable, until tx_ready
- tx_ready  out  1  one-cycle accept pulse for tx_data
- rx_data  out  8  head of the RX FIFO
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  client pops the head when rx_valid && rx_ready

Behaviour:
- Register map: TXD=0x40000018, RXD=0x4000001C, CON=0x40000020.
- CON fields: [3] RX-ready flag, cleared by the peripheral on an RXD read; [4] TX busy.
- Bus outputs are Moore functions of the state; no combinational path from inputs to outputs.
- rd and wr are never high together. Idle values: rd=0, wr=0, addr=0, wdata=0.
- Reset (synchronous, any state): state=S_INIT, settle counter=0, FIFO emptied; rx_valid=0, tx_ready=0, rd=0, wr=0.
- A bus cycle in flight is abandoned on reset; no partial transaction is retried.
- S_INIT (1 cycle): wr=1, addr=CON, wdata={27'b0,CON_INIT}; next S_POLL. This is the only CON write.
- S_POLL (1 cycle): rd=1, addr=CON; decision is taken on rdata in the same cycle:
  - rdata[3]=1 and FIFO not full -> S_RX (RX has priority over TX).
  - else if tx_valid=1 and rdata[4]=0 -> S_TX.
  - else -> S_POLL (back-to-back polls).
- S_RX (1 cycle): rd=1, addr=RXD; push rdata[7:0] into the FIFO this cycle; next S_HOLD.
- S_TX (1 cycle): wr=1, addr=TXD, wdata={24'b0,tx_data}; tx_ready=1; next S_HOLD.
- S_HOLD: counts SETTLE cycles with bus idle, then returns to S_POLL.
- FIFO full and CON[3]=1: RXD is not read and the flag is left set. Overrun of the peripheral's RXD register is accepted and not reported.
- FIFO:
  - push and pop in the same cycle are both performed; count is unchanged.
  - pop on empty is ignored.
  - pointers wrap modulo RX_DEPTH.
  - rx_data is registered at the head and valid whenever rx_valid=1.
- tx_valid deasserting before tx_ready is a client protocol violation; the behaviour is unspecified.
- Throughput: at most one TXD write per (2+SETTLE) cycles; actual rate is bounded by UART TX busy time.

Decomposition:
- Shared package uart_pkg:
  - UART_TXD_ADDR, UART_RXD_ADDR, UART_CON_ADDR.
  - CON bit indices: TXIE=0, RXIE=1, TXF=2, RXF=3, TXBUSY=4.
  - State enum: S_INIT, S_POLL, S_RX, S_TX, S_HOLD.
- One sub-module: uart_byte_fifo (parameter DEPTH, 8-bit, synchronous reset, push/pop/full/empty/head).

Test Plan:
- Reset 3 cycles, release -> cycle 1: wr=1, addr=0x40000020, wdata=0x3; cycle 2: rd=1, addr=0x40000020; no other write until tx_valid.
- Bus model CON rdata=0x00, tx_valid=1, tx_data=0xA5 -> next cycle wr=1, addr=0x40000018, wdata=0x000000A5, tx_ready=1; bus idle 3 cycles; then poll resumes.
- CON rdata=0x08, RXD rdata=0x3C, rx_ready=0 -> RXD read once; rx_valid=1, rx_data=0x3C the following cycle; CON re-polled after 3 idle cycles.
- CON rdata=0x08 with tx_valid=1 (0x55) in the same poll -> RXD read first; TXD write of 0x55 on a later poll after CON[3] clears.
- rx_ready=0, five RX bytes 0x01..0x05 offered -> FIFO holds 0x01..0x04; no RXD read while full; pop 0x01 -> 0x05 read next poll; order 0x02..0x05 preserved.
- reset asserted during S_HOLD after a TXD write with 2 bytes in the FIFO -> rx_valid=0 next cycle; S_INIT CON write repeats; no tx_ready until a new poll.
